// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - instruction memory fetch bus between sequencer (master) and imem (slave)
interface instruction_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] read_address;
  logic              imem_req;
  logic [7:0]        imem_data;
  logic              imem_valid;

  modport master (
    output read_address,
    output imem_req,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  read_address,
    input  imem_req,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer with run/step/halt and fetch timeout; optional BREAKPOINT_EN
module instruction_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                   i_clock,
  input  logic                   i_clear,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_halt_req,
  input  logic                   i_branch_taken,
  instruction_sequencer_if.master imem,
  output logic [7:0]             o_instruction,
  output logic                   o_exec_en,
  output logic                   o_halted,
  output logic                   o_fault,
  output logic [CNT_W-1:0]       o_retired_count
`ifdef BREAKPOINT_EN
  ,
  input  logic [ADDR_W-1:0]      i_bp_addr,
  output logic                   o_bp_hit
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int TMO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  // Counter value on the last FETCH cycle allowed to go without imem_valid.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr;
  logic              r_fault;
  logic              r_halt_pending;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [CNT_W-1:0]  r_retired;

  logic              w_imem_req;
  logic              w_exec_en;
  logic              w_halted;
  logic              w_branch;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_pc_exec;

`ifdef BREAKPOINT_EN
  logic              r_bp_hit;
  logic              w_bp_trip;
`endif

  // Branch target: only opcode 2'b11 with the datapath condition true uses the signed 2-bit offset.
  assign w_branch  = (r_instr[7:6] == 2'b11) && i_branch_taken;
  assign w_offset  = w_branch ? {{(ADDR_W-2){r_instr[1]}}, r_instr[1:0]} : '0;
  assign w_pc_exec = r_pc + ADDR_W'(1) + w_offset;

  // Next-state and Moore outputs; halt requests take priority over run/step everywhere.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_exec_en    = 1'b0;
    w_halted     = 1'b0;
`ifdef BREAKPOINT_EN
    w_bp_trip    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_halt_pending || i_halt_req) begin
          w_next_state = S_HALT;
        end else if (i_run || i_step) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem.imem_valid) begin
          w_next_state = S_EXEC;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_next_state = S_HALT;
        end
      end
      S_EXEC: begin
        w_exec_en = 1'b1;
        if (r_halt_pending || i_halt_req) begin
          w_next_state = S_HALT;
        end else if (i_run) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
`ifdef BREAKPOINT_EN
    // A resume out of a breakpoint stop is not re-checked, so the stopped address executes once.
    if (w_next_state == S_FETCH) begin
      if (r_state == S_IDLE && !r_bp_hit && r_pc == i_bp_addr) begin
        w_next_state = S_IDLE;
        w_bp_trip    = 1'b1;
      end else if (r_state == S_EXEC && w_pc_exec == i_bp_addr) begin
        w_next_state = S_IDLE;
        w_bp_trip    = 1'b1;
      end
    end
`endif
  end

  // State, PC, latched instruction, timeout, fault and retire counter.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_instr        <= 8'h00;
      r_fault        <= 1'b0;
      r_halt_pending <= 1'b0;
      r_tmo_cnt      <= '0;
      r_retired      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          if (i_halt_req) begin
            r_halt_pending <= 1'b1;
          end
          if (imem.imem_valid) begin
            r_instr   <= imem.imem_data;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_fault   <= 1'b1;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        S_EXEC: begin
          r_pc <= w_pc_exec;
          if (r_retired != {CNT_W{1'b1}}) begin
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BREAKPOINT_EN
  // Breakpoint flag: set on a stop, cleared when run/step restarts fetching from IDLE.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_bp_hit <= 1'b0;
    end else if (w_bp_trip) begin
      r_bp_hit <= 1'b1;
    end else if (r_state == S_IDLE && w_next_state == S_FETCH) begin
      r_bp_hit <= 1'b0;
    end
  end

  assign o_bp_hit = r_bp_hit;
`endif

  assign imem.read_address = r_pc;
  assign imem.imem_req     = w_imem_req;
  assign o_instruction     = r_instr;
  assign o_exec_en         = w_exec_en;
  assign o_halted          = w_halted;
  assign o_fault           = r_fault;
  assign o_retired_count   = r_retired;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer against a behavioural model
module tb_instruction_sequencer;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int TMO    = 15;

  logic             clk = 1'b0;
  logic             clear;
  logic             run;
  logic             step;
  logic             halt_req;
  logic             taken;
  logic [7:0]       instr;
  logic             exec_en;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;
`ifdef BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr = '1;
  logic              bp_hit;
`endif

  instruction_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_sequencer #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FETCH_TIMEOUT(TMO)
  ) dut (
    .i_clock        (clk),
    .i_clear        (clear),
    .i_run          (run),
    .i_step         (step),
    .i_halt_req     (halt_req),
    .i_branch_taken (taken),
    .imem           (bus),
    .o_instruction  (instr),
    .o_exec_en      (exec_en),
    .o_halted       (halted),
    .o_fault        (fault),
    .o_retired_count(retired)
`ifdef BREAKPOINT_EN
    ,
    .i_bp_addr      (bp_addr),
    .o_bp_hit       (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;
  int printed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: combinational read of the current address, refreshed after each edge.
  initial begin
    bus.imem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_data = mem[bus.read_address];
    end
  end

  // Behavioural model: what the sequencer is doing right now, compared then advanced each cycle.
  bit         m_known = 1'b0;
  bit         m_fetch, m_exec, m_halt, m_fault, m_pend;
  int         m_wait;
  logic [7:0] m_pc, m_instr;
  int         m_retired;

  always @(negedge clk) begin
    int off;
    if (m_known) begin
      check("read_address", 32'(bus.read_address), 32'(m_pc));
      check("imem_req", 32'(bus.imem_req), 32'(m_fetch));
      check("instruction", 32'(instr), 32'(m_instr));
      check("exec_en", 32'(exec_en), 32'(m_exec));
      check("halted", 32'(halted), 32'(m_halt));
      check("fault", 32'(fault), 32'(m_fault));
      check("retired_count", 32'(retired), 32'(m_retired));
    end
    if (clear) begin
      m_known = 1'b1;
      m_fetch = 0; m_exec = 0; m_halt = 0; m_fault = 0; m_pend = 0;
      m_wait = 0; m_pc = 8'h00; m_instr = 8'h00; m_retired = 0;
    end else if (m_known && !m_halt) begin
      if (m_exec) begin
        off = 0;
        if (m_instr[7:6] == 2'b11 && taken) begin
          off = m_instr[1] ? int'(m_instr[1:0]) - 4 : int'(m_instr[1:0]);
        end
        m_pc = 8'(int'(m_pc) + 1 + off);
        if (m_retired < 65535) m_retired++;
        m_exec = 0;
        if (m_pend || halt_req) m_halt = 1;
        else if (run) begin m_fetch = 1; m_wait = 0; end
      end else if (m_fetch) begin
        if (halt_req) m_pend = 1;
        if (bus.imem_valid) begin
          m_instr = bus.imem_data;
          m_fetch = 0;
          m_exec  = 1;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_fetch = 0; m_halt = 1; m_fault = 1;
          end
        end
      end else begin
        if (m_pend || halt_req) m_halt = 1;
        else if (run || step) begin m_fetch = 1; m_wait = 0; end
      end
    end
  end

  task automatic wait_exec_at(input logic [7:0] a, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exec_en && bus.read_address == a) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    int n;
    bit vmode;
    clear = 1; run = 0; step = 0; halt_req = 0; taken = 0; bus.imem_valid = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h14; mem[1] = 8'h25; mem[5] = 8'hC3;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_pc", 32'(bus.read_address), 32'h0);
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_exec", 32'(exec_en), 32'h0);
    check("rst_halted_fault", 32'({halted, fault}), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);

    // Free run, valid tied high: one instruction every 2 cycles
    tick(); clear = 0; run = 1; bus.imem_valid = 1;
    @(negedge clk); check("run_idle_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk); check("run_fetch_req", 32'(bus.imem_req), 32'h1);
    @(negedge clk); check("run_exec0", 32'({exec_en, instr}), 32'h114);
    @(negedge clk); check("run_pc1", 32'({exec_en, bus.read_address}), 32'h001);
    @(negedge clk); check("run_exec1", 32'({exec_en, instr}), 32'h125);
    @(negedge clk); check("run_pc2", 32'(bus.read_address), 32'h2);
                    check("run_retired2", 32'(retired), 32'h2);

    // Branch at PC 5, imm -1: taken stays at 5, not taken goes to 6
    tick(); clear = 1; run = 0; taken = 1;
    tick(); clear = 0; run = 1;
    wait_exec_at(8'h05, 60, "reach_pc5_taken");
    @(negedge clk); check("branch_taken_pc", 32'(bus.read_address), 32'h05);
    tick(); taken = 0;
    wait_exec_at(8'h05, 10, "reach_pc5_not_taken");
    @(negedge clk); check("branch_not_taken_pc", 32'(bus.read_address), 32'h06);

    // Single step from IDLE; a second step pulse during EXEC is ignored
    tick(); clear = 1; run = 0;
    tick(); clear = 0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); step = (c == 0 || c == 2);
      @(negedge clk); n += int'(exec_en);
    end
    check("step_exec_count", 32'(n), 32'd1);
    check("step_pc", 32'(bus.read_address), 32'h1);
    check("step_back_idle", 32'({bus.imem_req, exec_en}), 32'h0);

    // halt_req during FETCH, valid three cycles later
    tick(); clear = 1; bus.imem_valid = 0;
    tick(); clear = 0; run = 1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick(); halt_req = (c == 0); if (c == 3) bus.imem_valid = 1;
      @(negedge clk); n += int'(exec_en);
    end
    check("halt_exec_count", 32'(n), 32'd1);
    check("halt_held", 32'({halted, bus.imem_req}), 32'h2);
    check("halt_pc_frozen", 32'(bus.read_address), 32'h1);

    // Fetch timeout: exactly 15 FETCH cycles, then fault and halt; clear recovers
    tick(); clear = 1; bus.imem_valid = 0; run = 1;
    tick(); clear = 0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); n += int'(bus.imem_req);
    end
    check("timeout_fetch_cycles", 32'(n), 32'd15);
    check("timeout_fault_halt", 32'({fault, halted}), 32'h3);
    tick(); clear = 1;
    tick(); clear = 0; run = 0;
    @(negedge clk);
    check("clear_after_fault", 32'({fault, halted, bus.read_address}), 32'h000);

    // PC wrap 0xFF -> 0x00
    tick(); clear = 1; run = 1; bus.imem_valid = 1; taken = 0;
    tick(); clear = 0;
    wait_exec_at(8'hFF, 700, "reach_pc_ff");
    @(negedge clk); check("pc_wrap", 32'(bus.read_address), 32'h00);

    // Randomised run/step/halt/valid/branch traffic with occasional clears
    tick(); clear = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    vmode = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      clear    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      step     = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 79) == 0);
      taken    = 1'($urandom);
      if ($urandom_range(0, 99) == 0) vmode = ~vmode;
      bus.imem_valid = vmode ? 1'b0 : ($urandom_range(0, 99) < 70);
    end
    tick(); clear = 1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
